// File: rtl/ram8_arbiter_if.sv
// Bus bundle between the two requesters, the arbiter and the shared RAM8 bank.
// The slave modport is the arbiter's view; the master modport is the requester/bank side.
interface ram8_arbiter_if #(
    parameter int WIDTH  = 16,
    parameter int ADDR_W = 3
);
    logic              req0;
    logic              we0;
    logic [ADDR_W-1:0] addr0;
    logic [WIDTH-1:0]  wdata0;
    logic              ack0;
    logic [WIDTH-1:0]  rdata0;

    logic              req1;
    logic              we1;
    logic [ADDR_W-1:0] addr1;
    logic [WIDTH-1:0]  wdata1;
    logic              ack1;
    logic [WIDTH-1:0]  rdata1;

    logic [ADDR_W-1:0] ram_addr;
    logic [WIDTH-1:0]  ram_in;
    logic              ram_load;
    logic [WIDTH-1:0]  ram_out;
    logic              busy;

    modport slave (
        input  req0, we0, addr0, wdata0,
        input  req1, we1, addr1, wdata1,
        input  ram_out,
        output ack0, rdata0, ack1, rdata1,
        output ram_addr, ram_in, ram_load, busy
    );

    modport master (
        output req0, we0, addr0, wdata0,
        output req1, we1, addr1, wdata1,
        output ram_out,
        input  ack0, rdata0, ack1, rdata1,
        input  ram_addr, ram_in, ram_load, busy
    );
endinterface

// File: rtl/ram8_arbiter.sv
// Two-port round-robin arbiter and single-word access sequencer for one RAM8 bank.
// Each transaction takes IDLE -> ACCESS -> DONE; the command is latched at grant.
module ram8_arbiter #(
    parameter int WIDTH  = 16,
    parameter int ADDR_W = 3
) (
    input  logic            clk,
    input  logic            reset,
    ram8_arbiter_if.slave   bus
);
    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ACCESS = 2'd1;
    localparam logic [1:0] DONE   = 2'd2;

    logic [1:0]        state_r;
    logic [1:0]        next_state_s;
    logic              winner_s;
    logic              cmd_owner_r;
    logic              cmd_we_r;
    logic [ADDR_W-1:0] cmd_addr_r;
    logic [WIDTH-1:0]  cmd_wdata_r;
    logic              last_owner_r;
    logic              ack0_r;
    logic              ack1_r;
    logic [WIDTH-1:0]  rdata0_r;
    logic [WIDTH-1:0]  rdata1_r;

    // Winner selection: a lone requester always wins; under contention the non-last owner wins.
    always_comb begin
        winner_s = 1'b0;
        if (bus.req0 && bus.req1) begin
            winner_s = ~last_owner_r;
        end else if (bus.req1) begin
            winner_s = 1'b1;
        end else begin
            winner_s = 1'b0;
        end
    end

    // Next-state logic for the access sequencer.
    always_comb begin
        next_state_s = IDLE;
        case (state_r)
            IDLE: begin
                if (bus.req0 || bus.req1) begin
                    next_state_s = ACCESS;
                end else begin
                    next_state_s = IDLE;
                end
            end
            ACCESS:  next_state_s = DONE;
            DONE:    next_state_s = IDLE;
            default: next_state_s = IDLE;
        endcase
    end

    // State, command latch, read-data capture and ack generation.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r      <= IDLE;
            cmd_owner_r  <= 1'b0;
            cmd_we_r     <= 1'b0;
            cmd_addr_r   <= {ADDR_W{1'b0}};
            cmd_wdata_r  <= {WIDTH{1'b0}};
            last_owner_r <= 1'b1;
            ack0_r       <= 1'b0;
            ack1_r       <= 1'b0;
            rdata0_r     <= {WIDTH{1'b0}};
            rdata1_r     <= {WIDTH{1'b0}};
        end else begin
            state_r <= next_state_s;
            ack0_r  <= 1'b0;
            ack1_r  <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (bus.req0 || bus.req1) begin
                        cmd_owner_r <= winner_s;
                        cmd_we_r    <= winner_s ? bus.we1    : bus.we0;
                        cmd_addr_r  <= winner_s ? bus.addr1  : bus.addr0;
                        cmd_wdata_r <= winner_s ? bus.wdata1 : bus.wdata0;
                    end
                end
                ACCESS: begin
                    // Reads capture the bank's combinational output; writes leave rdata alone.
                    if (!cmd_we_r) begin
                        if (cmd_owner_r) begin
                            rdata1_r <= bus.ram_out;
                        end else begin
                            rdata0_r <= bus.ram_out;
                        end
                    end
                    ack0_r <= ~cmd_owner_r;
                    ack1_r <= cmd_owner_r;
                end
                DONE: begin
                    last_owner_r <= cmd_owner_r;
                end
                default: begin
                    last_owner_r <= last_owner_r;
                end
            endcase
        end
    end

    // Bank lines hold the latched command outside ACCESS; reset in the same cycle blocks a commit.
    assign bus.ram_addr = cmd_addr_r;
    assign bus.ram_in   = cmd_wdata_r;
    assign bus.ram_load = (state_r == ACCESS) && cmd_we_r && !reset;
    assign bus.busy     = (state_r != IDLE);

    // A reset arriving during DONE aborts the transaction, so the ack is withheld that cycle.
    assign bus.ack0   = ack0_r & ~reset;
    assign bus.ack1   = ack1_r & ~reset;
    assign bus.rdata0 = rdata0_r;
    assign bus.rdata1 = rdata1_r;
endmodule

// File: tb/tb_ram8_arbiter.sv
// Directed bench for ram8_arbiter with a behavioural RAM8 bank model.
module tb_ram8_arbiter;
    logic clk = 1'b0;
    logic reset;
    logic mem_clr;
    logic [15:0] mem [8];
    int checks = 0;
    int errors = 0;

    ram8_arbiter_if #(.WIDTH(16), .ADDR_W(3)) bus ();

    ram8_arbiter #(.WIDTH(16), .ADDR_W(3)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    assign bus.ram_out = mem[bus.ram_addr];

    always @(posedge clk) begin
        if (mem_clr) begin
            for (int k = 0; k < 8; k++) mem[k] <= 16'h0000;
        end else if (bus.ram_load) begin
            mem[bus.ram_addr] <= bus.ram_in;
        end
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Starts at a negedge in IDLE, ends at the negedge after DONE.
    task automatic txn(input bit port, input bit we, input logic [2:0] addr, input logic [15:0] wdata);
        if (port) begin
            bus.req1 = 1'b1; bus.we1 = we; bus.addr1 = addr; bus.wdata1 = wdata;
        end else begin
            bus.req0 = 1'b1; bus.we0 = we; bus.addr0 = addr; bus.wdata0 = wdata;
        end
        @(negedge clk);
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
        chk("txn_access_load", 16'(bus.ram_load), 16'(we));
        chk("txn_access_addr", 16'(bus.ram_addr), 16'(addr));
        chk("txn_access_busy", 16'(bus.busy), 16'd1);
        if (we) chk("txn_access_in", bus.ram_in, wdata);
        @(negedge clk);
        chk("txn_done_ack0", 16'(bus.ack0), 16'(!port));
        chk("txn_done_ack1", 16'(bus.ack1), 16'(port));
        chk("txn_done_load", 16'(bus.ram_load), 16'd0);
        @(negedge clk);
        chk("txn_idle_ack0", 16'(bus.ack0), 16'd0);
        chk("txn_idle_ack1", 16'(bus.ack1), 16'd0);
        chk("txn_idle_busy", 16'(bus.busy), 16'd0);
        chk("txn_idle_load", 16'(bus.ram_load), 16'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1; mem_clr = 1'b1;
        bus.req0 = 1'b0; bus.we0 = 1'b0; bus.addr0 = 3'd0; bus.wdata0 = 16'h0000;
        bus.req1 = 1'b0; bus.we1 = 1'b0; bus.addr1 = 3'd0; bus.wdata1 = 16'h0000;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0; mem_clr = 1'b0;
        #1;
        chk("rst_ack0", 16'(bus.ack0), 16'd0);
        chk("rst_ack1", 16'(bus.ack1), 16'd0);
        chk("rst_rdata0", bus.rdata0, 16'h0000);
        chk("rst_rdata1", bus.rdata1, 16'h0000);
        chk("rst_load", 16'(bus.ram_load), 16'd0);
        chk("rst_busy", 16'(bus.busy), 16'd0);
        chk("rst_addr", 16'(bus.ram_addr), 16'd0);

        // Port 0 write, port 1 read back
        txn(1'b0, 1'b1, 3'd5, 16'hBEEF);
        chk("wr_mem5", mem[5], 16'hBEEF);
        txn(1'b1, 1'b0, 3'd5, 16'h0000);
        chk("rd_rdata1", bus.rdata1, 16'hBEEF);
        chk("rd_rdata0", bus.rdata0, 16'h0000);

        // Preload words for later steps
        txn(1'b1, 1'b1, 3'd1, 16'h1111);
        txn(1'b1, 1'b1, 3'd4, 16'h4444);
        txn(1'b1, 1'b1, 3'd7, 16'h00FF);
        txn(1'b1, 1'b1, 3'd3, 16'h3333);
        chk("pre_mem7", mem[7], 16'h00FF);
        chk("pre_rdata1_held", bus.rdata1, 16'hBEEF);

        // Contention from reset: strict alternation 0,1,0,1
        reset = 1'b1;
        bus.req0 = 1'b1; bus.we0 = 1'b0; bus.addr0 = 3'd1;
        bus.req1 = 1'b1; bus.we1 = 1'b0; bus.addr1 = 3'd4;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            logic e;
            e = i[0];
            @(negedge clk);
            chk("rr_access_addr", 16'(bus.ram_addr), e ? 16'd4 : 16'd1);
            chk("rr_access_load", 16'(bus.ram_load), 16'd0);
            @(negedge clk);
            chk("rr_done_ack0", 16'(bus.ack0), 16'(!e));
            chk("rr_done_ack1", 16'(bus.ack1), 16'(e));
            if (e) chk("rr_rdata1", bus.rdata1, 16'h4444);
            else   chk("rr_rdata0", bus.rdata0, 16'h1111);
            if (i == 0) chk("rr_rdata1_cleared", bus.rdata1, 16'h0000);
            @(negedge clk);
            chk("rr_idle_busy", 16'(bus.busy), 16'd0);
            chk("rr_idle_acks", 16'({bus.ack0, bus.ack1}), 16'd0);
        end

        // Only port 1 requesting: it wins every time
        bus.req0 = 1'b0;
        bus.addr1 = 3'd5;
        for (int j = 0; j < 4; j++) begin
            @(negedge clk);
            chk("solo_access_addr", 16'(bus.ram_addr), 16'd5);
            chk("solo_access_ack0", 16'(bus.ack0), 16'd0);
            @(negedge clk);
            chk("solo_done_ack1", 16'(bus.ack1), 16'd1);
            chk("solo_done_ack0", 16'(bus.ack0), 16'd0);
            chk("solo_rdata1", bus.rdata1, 16'hBEEF);
            @(negedge clk);
            chk("solo_idle_ack1", 16'(bus.ack1), 16'd0);
            chk("solo_idle_ack0", 16'(bus.ack0), 16'd0);
        end
        bus.req1 = 1'b0;

        // Reset during ACCESS of a write
        bus.req0 = 1'b1; bus.we0 = 1'b1; bus.addr0 = 3'd2; bus.wdata0 = 16'h1234;
        @(negedge clk);
        bus.req0 = 1'b0;
        chk("abort_pre_load", 16'(bus.ram_load), 16'd1);
        reset = 1'b1;
        #1;
        chk("abort_load", 16'(bus.ram_load), 16'd0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("abort_busy", 16'(bus.busy), 16'd0);
        chk("abort_ack0", 16'(bus.ack0), 16'd0);
        chk("abort_mem2", mem[2], 16'h0000);
        @(negedge clk);
        chk("abort_ack0_late", 16'(bus.ack0), 16'd0);
        chk("abort_ack1_late", 16'(bus.ack1), 16'd0);
        chk("abort_busy_late", 16'(bus.busy), 16'd0);
        chk("abort_mem2_late", mem[2], 16'h0000);

        // Req dropped and address changed after grant
        bus.req0 = 1'b1; bus.we0 = 1'b0; bus.addr0 = 3'd7;
        @(negedge clk);
        bus.req0 = 1'b0; bus.addr0 = 3'd3;
        chk("drop_access_addr", 16'(bus.ram_addr), 16'd7);
        @(negedge clk);
        chk("drop_ack0", 16'(bus.ack0), 16'd1);
        chk("drop_rdata0", bus.rdata0, 16'h00FF);
        @(negedge clk);
        chk("drop_ack0_clear", 16'(bus.ack0), 16'd0);
        chk("drop_rdata0_held", bus.rdata0, 16'h00FF);
        chk("drop_busy", 16'(bus.busy), 16'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
